// File: rtl/mlaccel_pkg.sv
// Shared types for the main-memory arbiter: client owner tags, bus widths, round-robin pointer.
// Pure declarations, no timing or flow control of its own.
package mlaccel_pkg;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int RDATA_W = 64;
   localparam int CNT_W   = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CMEM = 2'd1,
      OWN_QMEM = 2'd2,
      OWN_SMEM = 2'd3
   } owner_e;

   typedef struct packed {
      owner_e owner;
      logic   is_read;
   } tag_t;

   typedef enum logic {
      RR_QMEM = 1'b0,
      RR_SMEM = 1'b1
   } rr_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mlaccel_memarb_tagpipe.sv
// Delay line of {owner, is_read} tags matching the memory read latency; one push per cycle.
// Latency DEPTH cycles from push to tail; no backpressure, async reset empties all in-flight tags.
module mlaccel_memarb_tagpipe
   import mlaccel_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic       i_clock,
   input  logic       i_resetn,
   input  logic [1:0] i_owner,
   input  logic       i_is_read,
   output logic [1:0] o_owner,
   output logic       o_is_read
);

   tag_t r_pipe [DEPTH];
   tag_t w_push;

   always_comb begin
      w_push.owner   = owner_e'(i_owner);
      w_push.is_read = i_is_read;
   end

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= w_push;
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_owner   = r_pipe[DEPTH-1].owner;
   assign o_is_read = r_pipe[DEPTH-1].is_read;

endmodule

// File: rtl/mlaccel_memarb.sv
// Single-port memory arbiter: compute always wins, host/sequencer round-robin, reads routed back by tag.
// Grant is combinational, read return MEM_LATENCY cycles later; compute is throttled only via cmem_hold.
module mlaccel_memarb
   import mlaccel_pkg::*;
#(
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 16
)
(
   input  logic               i_clock,
   input  logic               i_resetn,
   input  logic               i_cmem_ren,
   input  logic [1:0]         i_cmem_wen,
   input  logic [ADDR_W-1:0]  i_cmem_addr,
   input  logic [DATA_W-1:0]  i_cmem_wdata,
   output logic [RDATA_W-1:0] o_cmem_rdata,
   output logic               o_cmem_hold,
   input  logic               i_qmem_req,
   input  logic [1:0]         i_qmem_wen,
   input  logic [ADDR_W-1:0]  i_qmem_addr,
   input  logic [DATA_W-1:0]  i_qmem_wdata,
   output logic               o_qmem_gnt,
   output logic               o_qmem_rvalid,
   output logic [15:0]        o_qmem_rdata,
   input  logic               i_smem_valid,
   input  logic [ADDR_W-1:0]  i_smem_addr,
   output logic               o_smem_ready,
   output logic [31:0]        o_smem_data,
   output logic [ADDR_W-1:0]  o_mem_addr,
   output logic [1:0]         o_mem_wen,
   output logic [DATA_W-1:0]  o_mem_wdata,
   input  logic [RDATA_W-1:0] i_mem_rdata,
   output logic               o_conflict,
   input  logic               i_conflict_clr
);

   localparam logic [CNT_W-1:0] W_LIMIT = CNT_W'(STARVE_LIMIT);

   rr_e              r_rr;
   rr_e              w_rr_nxt;
   logic [CNT_W-1:0] r_q_cnt;
   logic [CNT_W-1:0] r_s_cnt;
   logic [CNT_W-1:0] w_q_cnt_nxt;
   logic [CNT_W-1:0] w_s_cnt_nxt;
   logic             r_hold;
   logic             r_conflict;
   logic             r_smem_inflight;

   logic             w_cmem_act;
   logic             w_smem_elig;
   logic             w_gnt_q;
   logic             w_gnt_s;
   logic [1:0]       w_push_owner;
   logic             w_push_rd;
   logic [1:0]       w_tail_owner;
   logic             w_tail_rd;
   logic             w_smem_ready;
   logic             w_hold_nxt;

   // Issue arbitration and memory-port mux; everything is forced quiet while reset is low.
   always_comb begin
      w_cmem_act   = i_cmem_ren | (|i_cmem_wen);
      w_smem_elig  = i_smem_valid & ~r_smem_inflight;
      w_gnt_q      = 1'b0;
      w_gnt_s      = 1'b0;
      o_mem_addr   = i_cmem_addr;
      o_mem_wen    = i_cmem_wen;
      o_mem_wdata  = i_cmem_wdata;
      w_push_owner = OWN_NONE;
      w_push_rd    = 1'b0;

      if (!w_cmem_act) begin
         if (i_qmem_req && w_smem_elig) begin
            if (r_rr == RR_QMEM) w_gnt_q = 1'b1;
            else                 w_gnt_s = 1'b1;
         end else if (i_qmem_req) begin
            w_gnt_q = 1'b1;
         end else if (w_smem_elig) begin
            w_gnt_s = 1'b1;
         end
      end

      if (w_cmem_act) begin
         w_push_owner = OWN_CMEM;
         w_push_rd    = i_cmem_ren;
      end else if (w_gnt_q) begin
         o_mem_addr   = i_qmem_addr;
         o_mem_wen    = i_qmem_wen;
         o_mem_wdata  = i_qmem_wdata;
         w_push_owner = OWN_QMEM;
         w_push_rd    = (i_qmem_wen == 2'b00);
      end else if (w_gnt_s) begin
         o_mem_addr   = i_smem_addr;
         o_mem_wen    = 2'b00;
         w_push_owner = OWN_SMEM;
         w_push_rd    = 1'b1;
      end

      if (!i_resetn) begin
         o_mem_wen    = 2'b00;
         w_gnt_q      = 1'b0;
         w_gnt_s      = 1'b0;
         w_push_owner = OWN_NONE;
         w_push_rd    = 1'b0;
      end
   end

   always_comb begin
      w_rr_nxt = r_rr;
      if (w_gnt_q)      w_rr_nxt = RR_SMEM;
      else if (w_gnt_s) w_rr_nxt = RR_QMEM;
   end

   // Hold looks one cycle ahead so it drops the cycle after the starving client is served.
   always_comb begin
      w_q_cnt_nxt = (!i_qmem_req || w_gnt_q) ? '0 : sat_inc(r_q_cnt);
      w_s_cnt_nxt = (!w_smem_elig || w_gnt_s) ? '0 : sat_inc(r_s_cnt);
      w_hold_nxt  = (i_qmem_req  && !w_gnt_q && (r_q_cnt >= W_LIMIT)) ||
                    (w_smem_elig && !w_gnt_s && (r_s_cnt >= W_LIMIT));
   end

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_rr            <= RR_QMEM;
         r_q_cnt         <= '0;
         r_s_cnt         <= '0;
         r_hold          <= 1'b0;
         r_conflict      <= 1'b0;
         r_smem_inflight <= 1'b0;
      end else begin
         r_rr    <= w_rr_nxt;
         r_q_cnt <= w_q_cnt_nxt;
         r_s_cnt <= w_s_cnt_nxt;
         r_hold  <= w_hold_nxt;
         if (w_cmem_act && r_hold) r_conflict <= 1'b1;
         else if (i_conflict_clr)  r_conflict <= 1'b0;
         if (w_gnt_s)           r_smem_inflight <= 1'b1;
         else if (w_smem_ready) r_smem_inflight <= 1'b0;
      end
   end

   mlaccel_memarb_tagpipe #(
      .DEPTH (MEM_LATENCY)
   ) u_tagpipe (
      .i_clock   (i_clock),
      .i_resetn  (i_resetn),
      .i_owner   (w_push_owner),
      .i_is_read (w_push_rd),
      .o_owner   (w_tail_owner),
      .o_is_read (w_tail_rd)
   );

   assign w_smem_ready  = w_tail_rd && (w_tail_owner == OWN_SMEM);
   assign o_smem_ready  = w_smem_ready;
   assign o_qmem_rvalid = w_tail_rd && (w_tail_owner == OWN_QMEM);
   assign o_qmem_gnt    = w_gnt_q;
   assign o_qmem_rdata  = i_mem_rdata[15:0];
   assign o_smem_data   = i_mem_rdata[31:0];
   assign o_cmem_rdata  = i_mem_rdata;
   assign o_cmem_hold   = r_hold;
   assign o_conflict    = r_conflict;

endmodule

// File: tb/tb_mlaccel_memarb.sv
// Directed bench for mlaccel_memarb with a 2-cycle behavioural memory model.
module tb_mlaccel_memarb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        cmem_ren;
   logic [1:0]  cmem_wen;
   logic [15:0] cmem_addr;
   logic [15:0] cmem_wdata;
   logic [63:0] cmem_rdata;
   logic        cmem_hold;
   logic        qmem_req;
   logic [1:0]  qmem_wen;
   logic [15:0] qmem_addr;
   logic [15:0] qmem_wdata;
   logic        qmem_gnt;
   logic        qmem_rvalid;
   logic [15:0] qmem_rdata;
   logic        smem_valid;
   logic [15:0] smem_addr;
   logic        smem_ready;
   logic [31:0] smem_data;
   logic [15:0] mem_addr;
   logic [1:0]  mem_wen;
   logic [15:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        conflict;
   logic        conflict_clr;

   int n_checks = 0;
   int n_fail   = 0;

   mlaccel_memarb #(.MEM_LATENCY(2), .STARVE_LIMIT(16)) dut (
      .i_clock        (clk),
      .i_resetn       (rstn),
      .i_cmem_ren     (cmem_ren),
      .i_cmem_wen     (cmem_wen),
      .i_cmem_addr    (cmem_addr),
      .i_cmem_wdata   (cmem_wdata),
      .o_cmem_rdata   (cmem_rdata),
      .o_cmem_hold    (cmem_hold),
      .i_qmem_req     (qmem_req),
      .i_qmem_wen     (qmem_wen),
      .i_qmem_addr    (qmem_addr),
      .i_qmem_wdata   (qmem_wdata),
      .o_qmem_gnt     (qmem_gnt),
      .o_qmem_rvalid  (qmem_rvalid),
      .o_qmem_rdata   (qmem_rdata),
      .i_smem_valid   (smem_valid),
      .i_smem_addr    (smem_addr),
      .o_smem_ready   (smem_ready),
      .o_smem_data    (smem_data),
      .o_mem_addr     (mem_addr),
      .o_mem_wen      (mem_wen),
      .o_mem_wdata    (mem_wdata),
      .i_mem_rdata    (mem_rdata),
      .o_conflict     (conflict),
      .i_conflict_clr (conflict_clr)
   );

   // Memory model: word[a] = 0x1000+a initially; address sampled at the issue edge, data two cycles on.
   logic        mem_init;
   logic [15:0] mem_arr [256];
   logic [7:0]  r_a1;
   logic [15:0] r_word;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= 16'h1000 + 16'(i);
      end else begin
         if (mem_wen[0]) mem_arr[mem_addr[7:0]][7:0]  <= mem_wdata[7:0];
         if (mem_wen[1]) mem_arr[mem_addr[7:0]][15:8] <= mem_wdata[15:8];
      end
      r_a1   <= mem_addr[7:0];
      r_word <= mem_arr[r_a1];
   end
   assign mem_rdata = {32'hD00D_F00D, ~r_word, r_word};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle_in();
      cmem_ren     = 1'b0;
      cmem_wen     = 2'b00;
      cmem_addr    = 16'h0000;
      cmem_wdata   = 16'h0000;
      qmem_req     = 1'b0;
      qmem_wen     = 2'b00;
      qmem_addr    = 16'h0000;
      qmem_wdata   = 16'h0000;
      smem_valid   = 1'b0;
      smem_addr    = 16'h0000;
      conflict_clr = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle_in();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   int nr;

   initial begin
      // Reset state, with all clients trying to issue while reset is held.
      mem_init = 1'b1;
      rstn     = 1'b0;
      idle_in();
      cmem_wen   = 2'b11;
      qmem_req   = 1'b1;
      smem_valid = 1'b1;
      settle();
      chk("rst_mem_wen", mem_wen, 2'b00);
      chk("rst_qgnt", qmem_gnt, 1'b0);
      chk("rst_rvalid", qmem_rvalid, 1'b0);
      chk("rst_sready", smem_ready, 1'b0);
      chk("rst_hold", cmem_hold, 1'b0);
      chk("rst_conflict", conflict, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      mem_init = 1'b0;
      idle_in();
      rstn = 1'b1;

      // 1: host read, grant same cycle, data two cycles later.
      qmem_req = 1'b1; qmem_addr = 16'h0010;
      settle();
      chk("t1_gnt", qmem_gnt, 1'b1);
      chk("t1_addr", mem_addr, 16'h0010);
      next_cycle(); qmem_req = 1'b0;
      settle();
      chk("t1_rv_early", qmem_rvalid, 1'b0);
      next_cycle();
      settle();
      chk("t1_rvalid", qmem_rvalid, 1'b1);
      chk("t1_rdata", qmem_rdata, 16'h1010);
      chk("t1_cmem_rdata", cmem_rdata, 64'hD00DF00D_EFEF1010);
      next_cycle();
      settle();
      chk("t1_rv_late", qmem_rvalid, 1'b0);

      // 2: host and sequencer together -> Q,S,Q; sequencer waits for its data.
      do_reset();
      cmem_addr = 16'h0077;
      qmem_req = 1'b1; qmem_addr = 16'h0030;
      smem_valid = 1'b1; smem_addr = 16'h0040;
      settle();
      chk("t2_g0_q", qmem_gnt, 1'b1);
      chk("t2_g0_addr", mem_addr, 16'h0030);
      next_cycle();
      settle();
      chk("t2_g1_q", qmem_gnt, 1'b0);
      chk("t2_g1_addr", mem_addr, 16'h0040);
      chk("t2_g1_wen", mem_wen, 2'b00);
      next_cycle(); qmem_addr = 16'h0031;
      settle();
      chk("t2_g2_q", qmem_gnt, 1'b1);
      chk("t2_g2_addr", mem_addr, 16'h0031);
      chk("t2_rv0", qmem_rvalid, 1'b1);
      chk("t2_rd0", qmem_rdata, 16'h1030);
      chk("t2_sr_early", smem_ready, 1'b0);
      next_cycle(); qmem_req = 1'b0;
      settle();
      chk("t2_sready", smem_ready, 1'b1);
      chk("t2_sdata", smem_data, 32'hEFBF1040);
      chk("t2_no_regrant", mem_addr, 16'h0077);
      next_cycle(); smem_valid = 1'b0;
      settle();
      chk("t2_rv1", qmem_rvalid, 1'b1);
      chk("t2_rd1", qmem_rdata, 16'h1031);
      chk("t2_sr_late", smem_ready, 1'b0);

      // 3+4: compute busy starves host, hold rises, conflict set/clear priority.
      do_reset();
      for (int k = 0; k < 18; k++) begin
         if (k > 0) next_cycle();
         cmem_ren = 1'b1; cmem_addr = 16'h0077;
         qmem_req = 1'b1; qmem_addr = 16'h0022;
         settle();
         if (k == 16) chk("t3_hold_c16", cmem_hold, 1'b0);
         if (k == 17) begin
            chk("t3_hold_c17", cmem_hold, 1'b1);
            chk("t3_cmem_wins", qmem_gnt, 1'b0);
            chk("t3_cmem_addr", mem_addr, 16'h0077);
            chk("t4_conf_pre", conflict, 1'b0);
         end
      end
      next_cycle(); conflict_clr = 1'b1;
      settle();
      chk("t4_conf_set", conflict, 1'b1);
      next_cycle(); cmem_ren = 1'b0;
      settle();
      chk("t4_set_wins", conflict, 1'b1);
      chk("t3_qgnt", qmem_gnt, 1'b1);
      chk("t3_hold_gcyc", cmem_hold, 1'b1);
      next_cycle(); conflict_clr = 1'b0; qmem_req = 1'b0;
      settle();
      chk("t4_conf_clr", conflict, 1'b0);
      chk("t3_hold_drop", cmem_hold, 1'b0);

      // 5: sequencer read then async reset -> its data is never reported.
      do_reset();
      smem_valid = 1'b1; smem_addr = 16'h0050;
      settle();
      chk("t5_sgrant", mem_addr, 16'h0050);
      next_cycle();
      smem_valid = 1'b0; rstn = 1'b0; qmem_req = 1'b1;
      settle();
      chk("t5_rst_qgnt", qmem_gnt, 1'b0);
      chk("t5_rst_sready", smem_ready, 1'b0);
      next_cycle(); rstn = 1'b1; qmem_req = 1'b0;
      nr = 0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) next_cycle();
         settle();
         if (smem_ready) nr++;
      end
      chk("t5_no_ready", nr, 0);
      next_cycle(); smem_valid = 1'b1; smem_addr = 16'h0051;
      settle();
      chk("t5_inflight_clr", mem_addr, 16'h0051);
      next_cycle();
      settle();
      chk("t5_single_out", mem_addr, 16'h0000);
      next_cycle();
      settle();
      chk("t5_sready", smem_ready, 1'b1);
      chk("t5_sdata", smem_data, 32'hEFAE1051);
      next_cycle(); smem_valid = 1'b0;

      // 6: host write then read back; the write itself returns nothing.
      do_reset();
      qmem_req = 1'b1; qmem_wen = 2'b11; qmem_addr = 16'h0020; qmem_wdata = 16'hBEEF;
      settle();
      chk("t6_wgnt", qmem_gnt, 1'b1);
      chk("t6_wen", mem_wen, 2'b11);
      chk("t6_wdata", mem_wdata, 16'hBEEF);
      next_cycle(); qmem_wen = 2'b00;
      settle();
      chk("t6_rgnt", qmem_gnt, 1'b1);
      next_cycle(); qmem_req = 1'b0;
      settle();
      chk("t6_no_wr_rv", qmem_rvalid, 1'b0);
      next_cycle();
      settle();
      chk("t6_rvalid", qmem_rvalid, 1'b1);
      chk("t6_rdata", qmem_rdata, 16'hBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
